instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Builds 32-bit ARM-subset machine words (data-processing, LDR/STR, B) from field-level requests.
//  These are exactly the words the processor's decode stage accepts.
//  Feeds the instruction-memory loader and the self-test program generator.
//  Word addresses are assigned at accept time.
//  A 2-entry output FIFO with valid/ready on both sides decouples producer and memory writer.
// PARAMETERS
//  ADDR_W     8  width of word-address counter (out_addr)
//  BASE_ADDR  0  word address given to the first word after reset or clr_addr
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  clr_addr   in   1       sync: reload address counter with BASE_ADDR
//  in_valid   in   1       request valid
//  in_ready   out  1       request accepted when in_valid & in_ready
//  in_kind    in   2       00=DP, 01=MEM, 10=BR, 11=illegal
//  in_cond    in   4       condition field [31:28]
//  in_cmd     in   4       DP cmd [24:21]
//  in_s       in   1       DP S bit (request)
//  in_imm_sel in   1       1=immediate src2, 0=register src2
//  in_rn      in   4       Rn
//  in_rd      in   4       Rd
//  in_rm      in   4       Rm (register src2)
//  in_shamt   in   5       shift amount (register src2)
//  in_sh      in   2       shift type (register src2)
//  in_rot     in   4       DP immediate rotate
//  in_imm8    in   8       DP immediate
//  in_imm12   in   12      MEM offset
//  in_load    in   1       MEM: 1=LDR, 0=STR
//  in_up      in   1       MEM: U bit
//  in_imm24   in   24      BR offset
//  out_valid  out  1       out_instr/out_addr valid
//  out_ready  in   1       consumer takes word when out_valid & out_ready
//  out_instr  out  32      encoded word
//  out_addr   out  ADDR_W  word address of out_instr
//  err_sticky out  1       set on any rejected request; cleared only by reset
//  err_cnt    out  8       rejected-request count, saturates at 255
// BEHAVIOUR
//  Reset (async): FIFO empty, out_valid=0, out_instr=0, out_addr=0.
//  Reset (async): addr counter=BASE_ADDR, err_sticky=0, err_cnt=0.
//  Reset (async): asserting mid-transfer drops all buffered words.
//  FIFO states EMPTY/ONE/FULL. in_ready = !FULL, driven from registered state only.
//  Latency: word accepted at edge N gives out_valid=1 after edge N when the FIFO was empty.
//  Simultaneous push+pop: state unchanged. In FULL, a pop frees a slot for the next cycle only.
//  Ordering strictly FIFO. out_instr/out_addr held stable while out_valid & !out_ready.
//  Encoding rules:
//   DP:  {cond,2'b00,I,cmd,S,Rn,Rd,src2}; I=in_imm_sel.
//   DP src2: I=1 -> {rot,imm8}; I=0 -> {shamt,sh,1'b0,Rm}.
//   DP cmd 1000..1011 (TST/TEQ/CMP/CMN): S forced 1, Rd forced 0.
//   DP cmd 1101 (MOV): Rn forced 0.
//   DP legal cmds: 0000-0100, 1000-1110. 0101/0110/0111/1111 are illegal.
//   MEM: {cond,2'b01,~I,1'b1,U,1'b0,1'b0,L,Rn,Rd,src2}.
//   MEM src2: I=1 -> imm12; I=0 -> register form.
//   BR:  {cond,2'b10,2'b10,imm24}.
//   cond=4'b1111 is illegal for all kinds.
//  Illegal request: accepted (consumes handshake), nothing enqueued, address not incremented.
//  Illegal request: err_sticky<=1, err_cnt+1 (saturating).
//  Address: each enqueued word takes current counter, then counter+1, wrapping 2^ADDR_W-1 -> 0.
//  clr_addr with a same-cycle push: pushed word gets BASE_ADDR, counter becomes BASE_ADDR+1.
//  clr_addr never disturbs words already in the FIFO.
// TESTING
//  DP ADD cond=E cmd=0100 I=1 Rn=2 Rd=1 imm8=5 -> out_instr=E2821005, out_addr=0.
//  CMP cmd=1010 S=0 Rn=3 Rd=7 imm8=0 I=1 -> E3530000 (S forced 1, Rd forced 0), out_addr=1.
//  LDR Rn=1 Rd=0 imm12=4 U=1 L=1 I=1 -> E5910004; then B imm24=2 -> EA000002, addr 2,3.
//  cmd=0101 or kind=11 -> in_ready held, no out_valid, err_sticky=1, err_cnt=1, next addr unchanged.
//  out_ready=0, push 3 words -> in_ready=0 after 2nd; release -> words in order, none lost.
//  ADDR_W=2, 5 words -> addrs 0,1,2,3,0; clr_addr with push -> that word's addr=BASE_ADDR.
//  Reset mid-stream -> out_valid=0 at once, FIFO empty.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request, output and status bundle of the instruction encoder.
// The master side issues field requests and drains encoded words.
interface instr_encoder_if #(
   parameter int ADDR_W = 8
);
   logic              clr_addr;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [3:0]        in_cond;
   logic [3:0]        in_cmd;
   logic              in_s;
   logic              in_imm_sel;
   logic [3:0]        in_rn;
   logic [3:0]        in_rd;
   logic [3:0]        in_rm;
   logic [4:0]        in_shamt;
   logic [1:0]        in_sh;
   logic [3:0]        in_rot;
   logic [7:0]        in_imm8;
   logic [11:0]       in_imm12;
   logic              in_load;
   logic              in_up;
   logic [23:0]       in_imm24;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              err_sticky;
   logic [7:0]        err_cnt;

   modport master (
      output clr_addr, in_valid, in_kind, in_cond, in_cmd, in_s,
             in_imm_sel, in_rn, in_rd, in_rm, in_shamt, in_sh, in_rot,
             in_imm8, in_imm12, in_load, in_up, in_imm24, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, err_sticky, err_cnt
   );

   modport slave (
      input  clr_addr, in_valid, in_kind, in_cond, in_cmd, in_s,
             in_imm_sel, in_rn, in_rd, in_rm, in_shamt, in_sh, in_rot,
             in_imm8, in_imm12, in_load, in_up, in_imm24, out_ready,
      output in_ready, out_valid, out_instr, out_addr, err_sticky, err_cnt
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes ARM-subset DP/LDR/STR/B words from field requests and
// queues them with word addresses in a 2-entry valid/ready FIFO.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic           clk,
   input  logic           reset,
   instr_encoder_if.slave bus
);
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_mem [2];
   logic [ADDR_W-1:0] r_madr [2];
   logic              r_wp;
   logic              r_rp;
   logic [ADDR_W-1:0] r_addr;
   logic              r_err;
   logic [7:0]        r_cnt;

   logic [ADDR_W-1:0] w_base;
   logic [ADDR_W-1:0] w_waddr;
   logic [31:0]       w_word;
   logic [11:0]       w_reg12;
   logic [11:0]       w_dp_src2;
   logic              w_cmp;
   logic              w_legal;
   logic              w_rdy;
   logic              w_acc;
   logic              w_push;
   logic              w_pop;
   logic              w_rej;

   assign w_base    = ADDR_W'(BASE_ADDR);
   assign w_rdy     = (r_state != S_FULL);
   assign w_acc     = bus.in_valid & w_rdy;
   assign w_push    = w_acc & w_legal;
   assign w_rej     = w_acc & ~w_legal;
   assign w_pop     = (r_state != S_EMPTY) & bus.out_ready;
   assign w_waddr   = bus.clr_addr ? w_base : r_addr;
   assign w_cmp     = (bus.in_cmd[3:2] == 2'b10);
   assign w_reg12   = {bus.in_shamt, bus.in_sh, 1'b0, bus.in_rm};
   assign w_dp_src2 = bus.in_imm_sel ? {bus.in_rot, bus.in_imm8} : w_reg12;

   always_comb begin
      w_word  = '0;
      w_legal = 1'b0;
      case (bus.in_kind)
         2'b00: begin
            w_legal = !(bus.in_cmd inside {4'b0101, 4'b0110, 4'b0111, 4'b1111});
            // compare ops always set flags and never write Rd; MOV has no Rn
            w_word  = {bus.in_cond, 2'b00, bus.in_imm_sel, bus.in_cmd,
                       bus.in_s | w_cmp,
                       (bus.in_cmd == 4'b1101) ? 4'h0 : bus.in_rn,
                       w_cmp ? 4'h0 : bus.in_rd, w_dp_src2};
         end
         2'b01: begin
            w_legal = 1'b1;
            w_word  = {bus.in_cond, 2'b01, ~bus.in_imm_sel, 1'b1, bus.in_up,
                       2'b00, bus.in_load, bus.in_rn, bus.in_rd,
                       bus.in_imm_sel ? bus.in_imm12 : w_reg12};
         end
         2'b10: begin
            w_legal = 1'b1;
            w_word  = {bus.in_cond, 4'b1010, bus.in_imm24};
         end
         default: begin
            w_legal = 1'b0;
            w_word  = '0;
         end
      endcase
      if (bus.in_cond == 4'hF) w_legal = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_EMPTY;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_EMPTY: if (w_push) w_next = S_ONE;
         S_ONE: begin
            if (w_push && !w_pop)      w_next = S_FULL;
            else if (!w_push && w_pop) w_next = S_EMPTY;
         end
         S_FULL:  if (w_pop) w_next = S_ONE;
         default: w_next = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i]  <= '0;
            r_madr[i] <= '0;
         end
         r_wp <= 1'b0;
         r_rp <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wp]  <= w_word;
            r_madr[r_wp] <= w_waddr;
            r_wp         <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr <= w_base;
         r_err  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         if (w_push)            r_addr <= w_waddr + ADDR_W'(1);
         else if (bus.clr_addr) r_addr <= w_base;
         if (w_rej) begin
            r_err <= 1'b1;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign bus.in_ready   = w_rdy;
   assign bus.out_valid  = (r_state != S_EMPTY);
   assign bus.out_instr  = r_mem[r_rp];
   assign bus.out_addr   = r_madr[r_rp];
   assign bus.err_sticky = r_err;
   assign bus.err_cnt    = r_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, errors, backpressure,
// address wrap/clear and asynchronous reset, on two parameterisations.
module tb_instr_encoder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(8)) b1 ();
   instr_encoder_if #(.ADDR_W(2)) b2 ();

   instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
      .clk(clk), .reset(reset), .bus(b1.slave)
   );
   instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) u_dut2 (
      .clk(clk), .reset(reset), .bus(b2.slave)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [3:0]  cond;
      logic [3:0]  cmd;
      logic        s;
      logic        imm_sel;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [4:0]  shamt;
      logic [1:0]  sh;
      logic [3:0]  rot;
      logic [7:0]  imm8;
      logic [11:0] imm12;
      logic        load;
      logic        up;
      logic [23:0] imm24;
   } req_t;

   function automatic req_t blank();
      req_t r;
      r.kind = 2'b00; r.cond = 4'hE; r.cmd = 4'h0; r.s = 1'b0;
      r.imm_sel = 1'b1; r.rn = 4'h0; r.rd = 4'h0; r.rm = 4'h0;
      r.shamt = 5'd0; r.sh = 2'b00; r.rot = 4'h0; r.imm8 = 8'h00;
      r.imm12 = 12'h000; r.load = 1'b0; r.up = 1'b0; r.imm24 = 24'h0;
      return r;
   endfunction

   function automatic req_t mk_br(input logic [23:0] imm);
      req_t r;
      r = blank();
      r.kind = 2'b10;
      r.imm24 = imm;
      return r;
   endfunction

   task automatic apply(input req_t r);
      b1.in_kind = r.kind; b1.in_cond = r.cond; b1.in_cmd = r.cmd;
      b1.in_s = r.s; b1.in_imm_sel = r.imm_sel; b1.in_rn = r.rn;
      b1.in_rd = r.rd; b1.in_rm = r.rm; b1.in_shamt = r.shamt;
      b1.in_sh = r.sh; b1.in_rot = r.rot; b1.in_imm8 = r.imm8;
      b1.in_imm12 = r.imm12; b1.in_load = r.load; b1.in_up = r.up;
      b1.in_imm24 = r.imm24;
   endtask

   task automatic send1(input req_t r);
      apply(r);
      b1.in_valid = 1'b1;
      @(posedge clk); #1;
      b1.in_valid = 1'b0;
   endtask

   task automatic send2(input logic [23:0] imm);
      b2.in_kind = 2'b10; b2.in_cond = 4'hE; b2.in_imm24 = imm;
      b2.in_valid = 1'b1;
      @(posedge clk); #1;
      b2.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      apply(blank());
      b1.in_valid = 0; b1.out_ready = 1; b1.clr_addr = 0;
      b2.in_valid = 0; b2.out_ready = 1; b2.clr_addr = 0;
      b2.in_cmd = 0; b2.in_s = 0; b2.in_imm_sel = 1; b2.in_rn = 0;
      b2.in_rd = 0; b2.in_rm = 0; b2.in_shamt = 0; b2.in_sh = 0;
      b2.in_rot = 0; b2.in_imm8 = 0; b2.in_imm12 = 0; b2.in_load = 0;
      b2.in_up = 0; b2.in_kind = 2'b10; b2.in_cond = 4'hE; b2.in_imm24 = 0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", b1.out_valid); end
      n_chk++; if (b1.out_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", b1.out_instr); end
      n_chk++; if (b1.out_addr !== 8'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", b1.out_addr); end
      n_chk++; if (b1.err_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sticky got=%b exp=0", b1.err_sticky); end
      n_chk++; if (b1.err_cnt !== 8'h0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", b1.err_cnt); end
      n_chk++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", b1.in_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_encode();
      req_t r;
      logic [31:0] exp_w [6];
      logic [7:0]  exp_a [6];
      req_t        rq [6];
      rq[0] = blank(); rq[0].cmd = 4'b0100; rq[0].rn = 2; rq[0].rd = 1; rq[0].imm8 = 5;
      rq[1] = blank(); rq[1].cmd = 4'b1010; rq[1].rn = 3; rq[1].rd = 7;
      rq[2] = blank(); rq[2].kind = 2'b01; rq[2].rn = 1; rq[2].imm12 = 12'h004;
      rq[2].up = 1; rq[2].load = 1;
      rq[3] = mk_br(24'h000002);
      r = blank(); r.cond = 4'h0; r.cmd = 4'b1101; r.s = 1; r.imm_sel = 0;
      r.rn = 5; r.rd = 3; r.rm = 4; r.shamt = 5'd2; r.sh = 2'b01;
      rq[4] = r;
      r = blank(); r.kind = 2'b01; r.cond = 4'h1; r.imm_sel = 0; r.rn = 2;
      r.rd = 6; r.rm = 7; r.sh = 2'b10;
      rq[5] = r;
      exp_w[0] = 32'hE2821005; exp_w[1] = 32'hE3530000;
      exp_w[2] = 32'hE5910004; exp_w[3] = 32'hEA000002;
      exp_w[4] = 32'h01B03124; exp_w[5] = 32'h17026047;
      for (int i = 0; i < 6; i++) exp_a[i] = 8'(i);
      for (int i = 0; i < 6; i++) begin
         send1(rq[i]);
         n_chk++; if (b1.out_instr !== exp_w[i] || b1.out_valid !== 1'b1) begin
            n_err++; $display("FAIL enc_word%0d got=%h v=%b exp=%h", i, b1.out_instr, b1.out_valid, exp_w[i]);
         end
         n_chk++; if (b1.out_addr !== exp_a[i]) begin
            n_err++; $display("FAIL enc_addr%0d got=%0d exp=%0d", i, b1.out_addr, exp_a[i]);
         end
      end
      tick();
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL enc_drain got=%b exp=0", b1.out_valid); end
   endtask

   task automatic test_illegal();
      req_t r;
      r = blank(); r.cmd = 4'b0101;
      send1(r);
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL ill_cmd_valid got=%b exp=0", b1.out_valid); end
      n_chk++; if (b1.err_sticky !== 1'b1) begin n_err++; $display("FAIL ill_sticky got=%b exp=1", b1.err_sticky); end
      n_chk++; if (b1.err_cnt !== 8'd1) begin n_err++; $display("FAIL ill_cnt1 got=%0d exp=1", b1.err_cnt); end
      n_chk++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got=%b exp=1", b1.in_ready); end
      r = blank(); r.kind = 2'b11;
      send1(r);
      r = mk_br(24'h000007); r.cond = 4'hF;
      send1(r);
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL ill_kind_valid got=%b exp=0", b1.out_valid); end
      n_chk++; if (b1.err_cnt !== 8'd3) begin n_err++; $display("FAIL ill_cnt3 got=%0d exp=3", b1.err_cnt); end
      send1(mk_br(24'h000001));
      n_chk++; if (b1.out_instr !== 32'hEA000001 || b1.out_addr !== 8'd6) begin
         n_err++; $display("FAIL ill_next got=%h@%0d exp=EA000001@6", b1.out_instr, b1.out_addr);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      b1.out_ready = 0;
      send1(mk_br(24'h000011));
      n_chk++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%b exp=1", b1.in_ready); end
      send1(mk_br(24'h000022));
      n_chk++; if (b1.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full got=%b exp=0", b1.in_ready); end
      apply(mk_br(24'h000033));
      b1.in_valid = 1;
      tick();
      n_chk++; if (b1.out_instr !== 32'hEA000011 || b1.out_addr !== 8'd7) begin
         n_err++; $display("FAIL bp_hold got=%h@%0d exp=EA000011@7", b1.out_instr, b1.out_addr);
      end
      b1.out_ready = 1;
      tick();
      n_chk++; if (b1.out_instr !== 32'hEA000022 || b1.out_addr !== 8'd8 || b1.in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_w2 got=%h@%0d r=%b exp=EA000022@8", b1.out_instr, b1.out_addr, b1.in_ready);
      end
      tick();
      b1.in_valid = 0;
      n_chk++; if (b1.out_instr !== 32'hEA000033 || b1.out_addr !== 8'd9) begin
         n_err++; $display("FAIL bp_w3 got=%h@%0d exp=EA000033@9", b1.out_instr, b1.out_addr);
      end
      tick();
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", b1.out_valid); end
   endtask

   task automatic test_reset_mid();
      b1.out_ready = 0;
      send1(mk_br(24'h000044));
      send1(mk_br(24'h000055));
      n_chk++; if (b1.out_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre got=%b exp=1", b1.out_valid); end
      #2 reset = 1'b1;
      #1;
      n_chk++; if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1) begin
         n_err++; $display("FAIL rm_async got v=%b r=%b exp v=0 r=1", b1.out_valid, b1.in_ready);
      end
      n_chk++; if (b1.err_cnt !== 8'd0 || b1.err_sticky !== 1'b0) begin
         n_err++; $display("FAIL rm_err got=%0d/%b exp=0/0", b1.err_cnt, b1.err_sticky);
      end
      tick();
      reset = 1'b0;
      b1.out_ready = 1;
      tick();
      n_chk++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL rm_empty got=%b exp=0", b1.out_valid); end
      send1(mk_br(24'h000066));
      n_chk++; if (b1.out_instr !== 32'hEA000066 || b1.out_addr !== 8'd0) begin
         n_err++; $display("FAIL rm_after got=%h@%0d exp=EA000066@0", b1.out_instr, b1.out_addr);
      end
      tick();
   endtask

   task automatic test_addr_wrap();
      logic [1:0] exp_a [5];
      exp_a[0] = 2; exp_a[1] = 3; exp_a[2] = 0; exp_a[3] = 1; exp_a[4] = 2;
      b2.out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         send2(24'(i + 1));
         n_chk++; if (b2.out_addr !== exp_a[i] || b2.out_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_addr%0d got=%0d v=%b exp=%0d", i, b2.out_addr, b2.out_valid, exp_a[i]);
         end
      end
      b2.clr_addr = 1;
      send2(24'h6);
      b2.clr_addr = 0;
      n_chk++; if (b2.out_addr !== 2'd2) begin n_err++; $display("FAIL clr_push got=%0d exp=2", b2.out_addr); end
      send2(24'h7);
      n_chk++; if (b2.out_addr !== 2'd3) begin n_err++; $display("FAIL clr_next got=%0d exp=3", b2.out_addr); end
      tick();
      b2.out_ready = 0;
      send2(24'h8);
      b2.clr_addr = 1;
      tick();
      b2.clr_addr = 0;
      n_chk++; if (b2.out_addr !== 2'd0 || b2.out_instr !== 32'hEA000008) begin
         n_err++; $display("FAIL clr_keep got=%h@%0d exp=EA000008@0", b2.out_instr, b2.out_addr);
      end
      send2(24'h9);
      b2.out_ready = 1;
      tick();
      n_chk++; if (b2.out_addr !== 2'd2 || b2.out_instr !== 32'hEA000009) begin
         n_err++; $display("FAIL clr_alone got=%h@%0d exp=EA000009@2", b2.out_instr, b2.out_addr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_encode();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_addr_wrap();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
